// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: syncs SPI commands, round-robin arbitrates them against local status writes into an 8x8 register file, serves reply bytes, raises irq on changed status
module spi_reg_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       commReady,
  input  logic [ADR_WIDTH-1:0]                       commAdr,
  input  logic [DATA_WIDTH-1:0]                      commData,
  input  logic                                       replyEn,
  output logic [DATA_WIDTH-1:0]                      replyData,
  input  logic                                       stsReq,
  input  logic [ADR_WIDTH-2:0]                       stsAdr,
  input  logic [DATA_WIDTH-1:0]                      stsData,
  output logic                                       stsAck,
  output logic [(2**(ADR_WIDTH-1))*DATA_WIDTH-1:0]   ctrlRegs,
  output logic                                       irq,
  output logic                                       adrErr
);
  localparam int N = 2**ADR_WIDTH;
  localparam int H = N/2;
  logic [DATA_WIDTH-1:0]  regs [N];
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist, rise;
  logic [ADR_WIDTH-1:0]   p_adr;
  logic [DATA_WIDTH-1:0]  p_data;
  logic                   p_rd, spi_pend, last_spi;
  logic [H-1:0]           changed;
  logic                   sts_act, spi_win, loc_win;
  assign rise    = sync[SYNC_STAGES-1] & ~hist;
  assign sts_act = stsReq & ~stsAck;
  assign spi_win = spi_pend & (~sts_act | ~last_spi);
  assign loc_win = sts_act & ~spi_win;
  assign irq     = |changed;
  for (genvar g = 0; g < H; g++) begin : g_ctrl
    assign ctrlRegs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      sync      <= '0;
      hist      <= 1'b0;
      p_adr     <= '0;
      p_data    <= '0;
      p_rd      <= 1'b0;
      spi_pend  <= 1'b0;
      last_spi  <= 1'b0;
      changed   <= '0;
      replyData <= '0;
      stsAck    <= 1'b0;
      adrErr    <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], commReady};
      hist   <= sync[SYNC_STAGES-1];
      stsAck <= loc_win;
      adrErr <= spi_win & ~p_rd & p_adr[ADR_WIDTH-1];
      if (spi_win) begin
        spi_pend <= 1'b0;
        last_spi <= 1'b1;
        if (p_rd) begin
          replyData <= regs[p_adr];
          if (p_adr[ADR_WIDTH-1]) changed[p_adr[ADR_WIDTH-2:0]] <= 1'b0;
        end else if (!p_adr[ADR_WIDTH-1]) begin
          regs[p_adr] <= p_data;
        end
      end
      if (loc_win) begin
        last_spi             <= 1'b0;
        regs[{1'b1, stsAdr}] <= stsData;
        if (regs[{1'b1, stsAdr}] != stsData) changed[stsAdr] <= 1'b1;
      end
      if (rise) begin
        spi_pend <= 1'b1;
        p_adr    <= commAdr;
        p_data   <= commData;
        p_rd     <= replyEn;
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter: directed stimulus against a transaction-level model of the register arbiter, checked every cycle plus literal expectations
module tb_spi_reg_arbiter;
  logic        clk = 0, rst = 0;
  logic        commReady = 0, replyEn = 0, stsReq = 0;
  logic [2:0]  commAdr = 0;
  logic [7:0]  commData = 0, stsData = 0;
  logic [1:0]  stsAdr = 0;
  logic [7:0]  replyData;
  logic        stsAck, irq, adrErr;
  logic [31:0] ctrlRegs;
  int checks = 0, failures = 0, err_cycles = 0;
  bit seen = 0;
  spi_reg_arbiter dut (
    .clk(clk), .rst(rst), .commReady(commReady), .commAdr(commAdr), .commData(commData),
    .replyEn(replyEn), .replyData(replyData), .stsReq(stsReq), .stsAdr(stsAdr),
    .stsData(stsData), .stsAck(stsAck), .ctrlRegs(ctrlRegs), .irq(irq), .adrErr(adrErr)
  );
  always #5 clk = ~clk;
  bit [7:0] m_regs [8];
  bit [3:0] m_chg;
  bit [7:0] m_reply, mp_data;
  bit       m_ack, m_err, m_last_spi, m_pend, mp_rd;
  bit [2:0] mp_adr;
  bit       s_q [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    bit spi_g, loc_g, rise, loc_act;
    bit [2:0] la;
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_chg = 0; m_reply = 0; m_ack = 0; m_err = 0; m_last_spi = 0; m_pend = 0;
      s_q.push_back(0);
      seen = 1;
    end else begin
      s_q.push_back(commReady);
      rise = s_q.size() >= 4 && s_q[$-2] && !s_q[$-3];
      loc_act = stsReq && !m_ack;
      spi_g = m_pend && (!loc_act || !m_last_spi);
      loc_g = loc_act && !spi_g;
      m_ack = loc_g;
      m_err = spi_g && !mp_rd && mp_adr >= 4;
      if (spi_g) begin
        m_pend = 0;
        m_last_spi = 1;
        if (mp_rd) begin
          m_reply = m_regs[mp_adr];
          if (mp_adr >= 4) m_chg[mp_adr-4] = 0;
        end else if (mp_adr < 4) m_regs[mp_adr] = mp_data;
      end
      if (loc_g) begin
        la = 3'(4 + stsAdr);
        if (m_regs[la] != stsData) m_chg[stsAdr] = 1;
        m_regs[la] = stsData;
        m_last_spi = 0;
      end
      if (rise) begin
        m_pend = 1; mp_adr = commAdr; mp_data = commData; mp_rd = replyEn;
      end
    end
    if (s_q.size() > 8) void'(s_q.pop_front());
  endtask
  always @(posedge clk) begin
    model_step();
    #1;
    if (seen) begin
      chk("replyData", replyData, m_reply);
      chk("stsAck", stsAck, m_ack);
      chk("adrErr", adrErr, m_err);
      chk("irq", irq, |m_chg);
      chk("ctrlRegs", ctrlRegs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      if (adrErr === 1'b1) err_cycles++;
    end
  end
  task automatic spi_cmd(input logic [2:0] a, input logic [7:0] d, input logic rd);
    commAdr = a; commData = d; replyEn = rd; commReady = 1;
    repeat (4) @(negedge clk);
    commReady = 0;
    repeat (6) @(negedge clk);
  endtask
  task automatic wait_ack(input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = stsAck;
    end
    chk(name, got, 1'b1);
    stsReq = 0;
    repeat (4) @(negedge clk);
  endtask
  task automatic local_write(input logic [1:0] a, input logic [7:0] d);
    stsAdr = a; stsData = d; stsReq = 1;
    wait_ack("local_ack");
  endtask
  task automatic arb(input logic [2:0] ra, input logic [1:0] la, input logic [7:0] ld);
    commAdr = ra; commData = 0; replyEn = 1; commReady = 1;
    repeat (3) @(negedge clk);
    stsAdr = la; stsData = ld; stsReq = 1;
    @(negedge clk);
    commReady = 0;
    wait_ack("arb_ack");
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int e0;
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      commReady = ~commReady;
    end
    commReady = 0;
    @(negedge clk);
    chk("rst_reply", replyData, 8'h00);
    chk("rst_ctrl", ctrlRegs, 32'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ack", stsAck, 1'b0);
    chk("rst_err", adrErr, 1'b0);
    rst = 1;
    repeat (4) @(negedge clk);
    spi_cmd(3'd1, 8'hA5, 1'b0);
    chk("wr1_ctrl", ctrlRegs, 32'h0000A500);
    chk("wr1_err", err_cycles, 0);
    local_write(2'd2, 8'h3C);
    chk("sts_irq_set", irq, 1'b1);
    spi_cmd(3'd6, 8'h00, 1'b1);
    chk("rd6_reply", replyData, 8'h3C);
    chk("rd6_irq", irq, 1'b0);
    local_write(2'd2, 8'h3C);
    chk("same_irq", irq, 1'b0);
    arb(3'd7, 2'd3, 8'h11);
    chk("arb_spi_first_reply", replyData, 8'h00);
    chk("arb_spi_first_irq", irq, 1'b1);
    spi_cmd(3'd0, 8'h22, 1'b0);
    chk("wr0_ctrl", ctrlRegs, 32'h0000A522);
    arb(3'd7, 2'd3, 8'h55);
    chk("arb_loc_first_reply", replyData, 8'h55);
    chk("arb_loc_first_irq", irq, 1'b0);
    local_write(2'd1, 8'h77);
    e0 = err_cycles;
    spi_cmd(3'd5, 8'hFF, 1'b0);
    chk("adrerr_pulses", err_cycles - e0, 1);
    spi_cmd(3'd5, 8'h00, 1'b1);
    chk("reg5_kept", replyData, 8'h77);
    commAdr = 3'd2; commData = 8'h99; replyEn = 0; commReady = 1;
    repeat (3) @(negedge clk);
    rst = 0; commReady = 0;
    @(negedge clk);
    chk("rstg_ctrl", ctrlRegs, 32'h0);
    chk("rstg_reply", replyData, 8'h00);
    chk("rstg_irq", irq, 1'b0);
    rst = 1;
    repeat (6) @(negedge clk);
    chk("rstg_after", ctrlRegs, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
